// File: rtl/if_prefetch_buf_pkg.sv
// Shared types for the instruction prefetch buffer: address/instruction
// words, the {pc, inst} entry carried through the FIFO, and the fetch stride.
package if_prefetch_buf_pkg;

  typedef logic [31:0] InstAddr_t;
  typedef logic [31:0] Inst_t;

  typedef struct packed {
    InstAddr_t pc;
    Inst_t     inst;
  } fetch_entry_t;

  localparam int unsigned INST_BYTES = 4;

endpackage

// File: rtl/if_prefetch_buf_inst_fifo.sv
// inst_fifo: synchronous DEPTH-entry FIFO of fetch_entry_t with push, pop,
// flush, occupancy count and a combinational head output. The caller must
// not push when full nor pop when empty.
module inst_fifo
  import if_prefetch_buf_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  fetch_entry_t     entry_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic [CNT_W-1:0] count_o,
  output fetch_entry_t     head_o
);

  localparam int PTR_W = $clog2(DEPTH);

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Next pointer/occupancy; flush wins over any push or pop in the same cycle.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push_i, pop_i})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state: pointers and count, cleared by reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage: data only, no reset needed since count gates visibility.
  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= entry_i;
  end

  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/if_prefetch_buf.sv
// if_prefetch_buf: instruction-fetch stage between the instruction ROM and
// decode. Walks the PC sequentially, captures {pc, inst} into inst_fifo and
// hands entries to decode over valid/ready. redirect_i flushes and reloads PC.
// Optional build macro PREFETCH_PERF_EN adds fetch and full-stall counters.
module if_prefetch_buf
  import if_prefetch_buf_pkg::*;
#(
  parameter int        DEPTH    = 4,
  parameter InstAddr_t RESET_PC = 32'h0000_0000
) (
  input  logic                       clk,
  input  logic                       rst,
  output InstAddr_t                  rom_addr_o,
  output logic                       rom_ce_o,
  input  Inst_t                      rom_data_i,
  output logic                       id_valid_o,
  input  logic                       id_ready_i,
  output InstAddr_t                  id_pc_o,
  output Inst_t                      id_inst_o,
  input  logic                       redirect_i,
  input  InstAddr_t                  redirect_pc_i,
  output logic [$clog2(DEPTH+1)-1:0] count_o
`ifdef PREFETCH_PERF_EN
  ,
  output logic [31:0]                fetch_cnt_o,
  output logic [31:0]                full_stall_cnt_o
`endif
);

  localparam int               CNT_W    = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  InstAddr_t        pc_q, pc_d;
  logic             ce_q, ce_d;
  logic             push, pop;
  logic [CNT_W-1:0] count;
  fetch_entry_t     wr_entry, head;
  logic             unused_redirect_lsb;

  // Fetch is gated by occupancy before any same-cycle pop, so a full buffer
  // stalls for one cycle even while decode drains it; this keeps id_ready_i
  // off the ROM enable path.
  assign rom_ce_o   = ce_q && (count < FULL_CNT) && !redirect_i;
  assign rom_addr_o = pc_q;
  assign push       = rom_ce_o;
  assign id_valid_o = (count != '0) && !redirect_i;
  assign pop        = id_valid_o && id_ready_i;

  assign wr_entry.pc   = pc_q;
  assign wr_entry.inst = rom_data_i;
  assign id_pc_o       = head.pc;
  assign id_inst_o     = head.inst;

  // Redirect targets are word aligned; the low two bits are dropped.
  assign unused_redirect_lsb = ^redirect_pc_i[1:0];

  // Next PC and fetch enable: redirect reloads, a fetch advances by one word.
  always_comb begin
    ce_d = 1'b1;
    pc_d = pc_q;
    if (redirect_i) begin
      pc_d = {redirect_pc_i[31:2], 2'b00};
    end else if (push) begin
      pc_d = pc_q + InstAddr_t'(INST_BYTES);
    end
  end

  // PC and fetch-enable registers; enable rises one cycle after reset release.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q <= RESET_PC;
      ce_q <= 1'b0;
    end else begin
      pc_q <= pc_d;
      ce_q <= ce_d;
    end
  end

  inst_fifo #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_inst_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .entry_i (wr_entry),
    .pop_i   (pop),
    .flush_i (redirect_i),
    .count_o (count),
    .head_o  (head)
  );

  assign count_o = count;

`ifdef PREFETCH_PERF_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] full_stall_cnt_q, full_stall_cnt_d;
  logic        full_stall;

  assign full_stall = ce_q && (count == FULL_CNT) && !redirect_i;

  // Free-running perf counters; only reset clears them, redirect does not.
  always_comb begin
    fetch_cnt_d      = fetch_cnt_q + (push ? 32'd1 : 32'd0);
    full_stall_cnt_d = full_stall_cnt_q + (full_stall ? 32'd1 : 32'd0);
  end

  // Perf counter registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_cnt_q      <= '0;
      full_stall_cnt_q <= '0;
    end else begin
      fetch_cnt_q      <= fetch_cnt_d;
      full_stall_cnt_q <= full_stall_cnt_d;
    end
  end

  assign fetch_cnt_o      = fetch_cnt_q;
  assign full_stall_cnt_o = full_stall_cnt_q;
`endif

endmodule

// File: tb/tb_if_prefetch_buf.sv
// Self-checking bench for if_prefetch_buf: a queue-based reference predicts
// every cycle's outputs, plus directed checks of the delivered PC sequence.
module tb_if_prefetch_buf;
  import if_prefetch_buf_pkg::*;

  localparam int          DEPTH    = 4;
  localparam int          CNT_W    = $clog2(DEPTH + 1);
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] XOR_K    = 32'hA5A5_A5A5;

  logic             clk = 1'b0;
  logic             rst;
  logic [31:0]      rom_addr;
  logic             rom_ce;
  logic [31:0]      rom_data;
  logic             id_valid;
  logic             id_ready;
  logic [31:0]      id_pc;
  logic [31:0]      id_inst;
  logic             redirect;
  logic [31:0]      redirect_pc;
  logic [CNT_W-1:0] count;
`ifdef PREFETCH_PERF_EN
  logic [31:0]      fetch_cnt;
  logic [31:0]      stall_cnt;
  logic [31:0]      m_fc;
  logic [31:0]      m_sc;
`endif

  always #5 clk = ~clk;

  // ROM model: combinational data derived from the address.
  assign rom_data = rom_addr ^ XOR_K;

  if_prefetch_buf #(
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .rom_addr_o    (rom_addr),
    .rom_ce_o      (rom_ce),
    .rom_data_i    (rom_data),
    .id_valid_o    (id_valid),
    .id_ready_i    (id_ready),
    .id_pc_o       (id_pc),
    .id_inst_o     (id_inst),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .count_o       (count)
`ifdef PREFETCH_PERF_EN
    ,
    .fetch_cnt_o      (fetch_cnt),
    .full_stall_cnt_o (stall_cnt)
`endif
  );

  int          n_pass  = 0;
  int          n_total = 0;
  logic [63:0] m_q[$];
  logic [31:0] m_pc;
  logic        m_ce;
  bit          m_known = 0;
  logic [31:0] got[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chk_got(input string tag, input int idx, input logic [31:0] exp);
    logic [63:0] obs;
    obs = (idx < got.size()) ? 64'(got[idx]) : 64'hDEAD_BEEF_DEAD_BEEF;
    chk(tag, obs, 64'(exp));
  endtask

  // One clock: compare against the reference, then advance the reference.
  task automatic step();
    logic m_fetch;
    logic m_valid;
    logic m_full;
    #1;
    m_fetch = m_ce && (m_q.size() < DEPTH) && !redirect;
    m_valid = (m_q.size() != 0) && !redirect;
    m_full  = m_ce && (m_q.size() == DEPTH) && !redirect;
    if (m_known) begin
      chk("rom_ce", 64'(rom_ce), 64'(m_fetch));
      chk("rom_addr", 64'(rom_addr), 64'(m_pc));
      chk("id_valid", 64'(id_valid), 64'(m_valid));
      chk("count", 64'(count), 64'(m_q.size()));
      if (m_valid) chk("head", {id_pc, id_inst}, m_q[0]);
`ifdef PREFETCH_PERF_EN
      chk("fetch_cnt", 64'(fetch_cnt), 64'(m_fc));
      chk("stall_cnt", 64'(stall_cnt), 64'(m_sc));
`endif
    end
    if (id_valid === 1'b1 && id_ready === 1'b1) got.push_back(id_pc);
    @(posedge clk);
    if (!rst) begin
      m_known = 1;
      m_q.delete();
      m_pc = RESET_PC;
      m_ce = 1'b0;
`ifdef PREFETCH_PERF_EN
      m_fc = '0;
      m_sc = '0;
`endif
    end else if (redirect) begin
      m_q.delete();
      m_pc = {redirect_pc[31:2], 2'b00};
      m_ce = 1'b1;
    end else begin
`ifdef PREFETCH_PERF_EN
      if (m_full) m_sc = m_sc + 32'd1;
      if (m_fetch) m_fc = m_fc + 32'd1;
`endif
      if (m_valid && id_ready) void'(m_q.pop_front());
      if (m_fetch) begin
        m_q.push_back({m_pc, m_pc ^ XOR_K});
        m_pc = m_pc + 32'd4;
      end
      m_ce = 1'b1;
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0; id_ready = 1'b1; redirect = 1'b0; redirect_pc = '0;

    // Reset state
    step(); step();
    #1;
    chk("rst_ce", 64'(rom_ce), 64'd0);
    chk("rst_valid", 64'(id_valid), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_addr", 64'(rom_addr), 64'(RESET_PC));

    // Release with ready=1: first valid two cycles later, then +4 each cycle
    rst = 1'b1; got.delete();
    step(); step();
    #1;
    chk("first_valid", 64'(id_valid), 64'd1);
    chk("first_pc", 64'(id_pc), 64'h0);
    chk("first_inst", 64'(id_inst), 64'(32'h0 ^ XOR_K));
    repeat (4) step();
    chk_got("seq0", 0, 32'h0);
    chk_got("seq1", 1, 32'h4);
    chk_got("seq2", 2, 32'h8);
    chk_got("seq3", 3, 32'hC);

    // Ready low: fills to DEPTH and stalls at 16, then drains in order
    rst = 1'b0; step();
    rst = 1'b1; id_ready = 1'b0; got.delete();
    step();
    repeat (10) step();
    #1;
    chk("full_count", 64'(count), 64'(DEPTH));
    chk("full_ce", 64'(rom_ce), 64'd0);
    chk("full_addr", 64'(rom_addr), 64'd16);
    id_ready = 1'b1;
    repeat (6) step();
    chk_got("drain0", 0, 32'd0);
    chk_got("drain1", 1, 32'd4);
    chk_got("drain2", 2, 32'd8);
    chk_got("drain3", 3, 32'd12);
    chk_got("drain4", 4, 32'd16);

    // Redirect with count=3, unaligned target
    rst = 1'b0; step();
    rst = 1'b1; id_ready = 1'b0;
    step();
    repeat (3) step();
    #1;
    chk("pre_redir_count", 64'(count), 64'd3);
    redirect = 1'b1; redirect_pc = 32'h0000_0103; id_ready = 1'b1;
    #1;
    chk("redir_valid", 64'(id_valid), 64'd0);
    chk("redir_ce", 64'(rom_ce), 64'd0);
    step();
    redirect = 1'b0; got.delete();
    #1;
    chk("post_redir_count", 64'(count), 64'd0);
    chk("post_redir_addr", 64'(rom_addr), 64'h100);
    repeat (3) step();
    chk_got("redir_first", 0, 32'h100);

    // Redirect near the top of the address space: wraps to 0
    got.delete(); redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    step();
    redirect = 1'b0;
    repeat (6) step();
    chk_got("wrap0", 0, 32'hFFFF_FFF8);
    chk_got("wrap1", 1, 32'hFFFF_FFFC);
    chk_got("wrap2", 2, 32'h0000_0000);
    chk_got("wrap3", 3, 32'h0000_0004);

    // Back-to-back redirects: the last target wins
    got.delete(); redirect = 1'b1; redirect_pc = 32'h300;
    step();
    redirect_pc = 32'h400;
    step();
    redirect = 1'b0;
    repeat (3) step();
    chk_got("b2b_first", 0, 32'h400);

    // Mid-stream reset with count=2
    id_ready = 1'b0; redirect = 1'b1; redirect_pc = 32'h200;
    step();
    redirect = 1'b0;
    step(); step();
    #1;
    chk("pre_rst_count", 64'(count), 64'd2);
    rst = 1'b0;
    step();
    #1;
    chk("midrst_count", 64'(count), 64'd0);
    chk("midrst_valid", 64'(id_valid), 64'd0);
    chk("midrst_ce", 64'(rom_ce), 64'd0);
    chk("midrst_addr", 64'(rom_addr), 64'(RESET_PC));
    rst = 1'b1; id_ready = 1'b1; got.delete();
    step();
    repeat (3) step();
    chk_got("midrst_resume", 0, RESET_PC);

`ifdef PREFETCH_PERF_EN
    // Perf counters: 6 fetches, 5 full-stall cycles, redirect keeps both
    rst = 1'b0; step();
    rst = 1'b1; id_ready = 1'b0;
    step();
    step();
    id_ready = 1'b1;
    step(); step();
    id_ready = 1'b0;
    repeat (3) step();
    #1;
    chk("perf_fc6", 64'(fetch_cnt), 64'd6);
    chk("perf_sc0", 64'(stall_cnt), 64'd0);
    repeat (5) step();
    #1;
    chk("perf_fc_full", 64'(fetch_cnt), 64'd6);
    chk("perf_sc5", 64'(stall_cnt), 64'd5);
    redirect = 1'b1; redirect_pc = 32'h0;
    step();
    redirect = 1'b0;
    #1;
    chk("perf_fc_redir", 64'(fetch_cnt), 64'd6);
    chk("perf_sc_redir", 64'(stall_cnt), 64'd5);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
